// File: rtl/gb66_to_byte.sv
// gb66_to_byte: serialises one 66-bit block (2-bit sync header + 64-bit
// payload) into eight byte slots for a downstream 8b/10b encoder. Each
// slot lasts BYTE_CYCLES clocks. Data blocks send their payload bytes as
// D-symbols. Control blocks replace byte 0 with K28.5. Blocks with an
// invalid header are sent as eight K30.7 symbols and counted in err_cnt.
module gb66_to_byte #(
  parameter int BYTE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blk_valid,
  input  logic [65:0] blk_in,
  output logic        blk_ready,
  output logic        en,
  output logic [7:0]  data_out,
  output logic        kin,
  output logic        hdr_err,
  output logic [15:0] err_cnt,
  output logic        busy
);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  typedef enum logic [1:0] {
    HDR_DATA,
    HDR_CTRL,
    HDR_BAD
  } hdr_e;

  localparam logic [3:0] SLOT_LAST = 4'(BYTE_CYCLES - 1);
  localparam logic [2:0] BYTE_LAST = 3'd7;
  localparam logic [7:0] K28_5     = 8'hBC;
  localparam logic [7:0] K30_7     = 8'hFE;

  state_e      state_q, state_d;
  hdr_e        hdr_q, hdr_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [3:0]  slot_cnt_q, slot_cnt_d;
  logic [63:0] payload_q, payload_d;
  logic        hdr_err_q, hdr_err_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic        slot_last;
  logic        block_last;
  logic        accept;
  hdr_e        hdr_in;

  // Map the incoming sync header onto its block class.
  always_comb begin
    unique case (blk_in[1:0])
      2'b01:   hdr_in = HDR_DATA;
      2'b10:   hdr_in = HDR_CTRL;
      default: hdr_in = HDR_BAD;
    endcase
  end

  // Handshake: a new block is taken when idle or on the very last cycle of
  // byte 7, so back-to-back blocks run with no idle slot between them.
  // Reset forces ready low so a block offered during reset is never taken.
  always_comb begin
    slot_last  = (slot_cnt_q == SLOT_LAST);
    block_last = (state_q == SEND) && (byte_idx_q == BYTE_LAST) && slot_last;
    blk_ready  = !rst && ((state_q == IDLE) || block_last);
    accept     = blk_valid && blk_ready;
  end

  // Next-state logic: load a block on acceptance, otherwise step through
  // the slot and byte counters while sending.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    hdr_d      = hdr_q;
    byte_idx_d = byte_idx_q;
    slot_cnt_d = slot_cnt_q;
    payload_d  = payload_q;
    hdr_err_d  = 1'b0;
    err_cnt_d  = err_cnt_q;

    if (accept) begin
      state_d    = SEND;
      hdr_d      = hdr_in;
      byte_idx_d = 3'd0;
      slot_cnt_d = 4'd0;
      payload_d  = blk_in[65:2];
      if (hdr_in == HDR_BAD) begin
        hdr_err_d = 1'b1;
        if (err_cnt_q != 16'hFFFF) begin
          err_cnt_d = err_cnt_q + 16'd1;
        end
      end
    end else if (state_q == SEND) begin
      if (slot_last) begin
        slot_cnt_d = 4'd0;
        if (byte_idx_q == BYTE_LAST) begin
          state_d    = IDLE;
          byte_idx_d = 3'd0;
        end else begin
          byte_idx_d = byte_idx_q + 3'd1;
        end
      end else begin
        slot_cnt_d = slot_cnt_q + 4'd1;
      end
    end
  end

  // Control and status registers; a synchronous reset aborts any block.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= IDLE;
      hdr_q      <= HDR_DATA;
      byte_idx_q <= 3'd0;
      slot_cnt_q <= 4'd0;
      hdr_err_q  <= 1'b0;
      err_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      byte_idx_q <= byte_idx_d;
      slot_cnt_q <= slot_cnt_d;
      hdr_err_q  <= hdr_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Payload holding register, written only on acceptance.
  always_ff @(posedge clk) begin
    // NOTE: the payload is a pure datapath register with no reset; its
    // contents are only observed while in SEND, after a load.
    payload_q <= payload_d;
  end

  // Output mux: choose the byte for the current slot and its symbol type.
  // Outputs depend only on registered state, so they stay stable for the
  // whole slot.
  always_comb begin
    data_out = 8'h00;
    kin      = 1'b0;
    if (state_q == SEND) begin
      unique case (hdr_q)
        HDR_BAD: begin
          data_out = K30_7;
          kin      = 1'b1;
        end
        HDR_CTRL: begin
          if (byte_idx_q == 3'd0) begin
            data_out = K28_5;
            kin      = 1'b1;
          end else begin
            data_out = payload_q[{byte_idx_q, 3'b000} +: 8];
          end
        end
        default: begin
          data_out = payload_q[{byte_idx_q, 3'b000} +: 8];
        end
      endcase
    end
  end

  assign en      = (state_q == SEND);
  assign busy    = en;
  assign hdr_err = hdr_err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_gb66_to_byte.sv
// Bench for gb66_to_byte. The driver pushes the expected per-cycle output
// of each accepted block into a queue. The monitor pops one entry on every
// en cycle and checks idle outputs otherwise. A second instance with
// BYTE_CYCLES=1 is checked directly.
module tb_gb66_to_byte;

  localparam int BC = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, blk_valid, blk_ready, en, kin, hdr_err, busy;
  logic [65:0] blk_in;
  logic [7:0]  data_out;
  logic [15:0] err_cnt;

  logic        rst1, blk_valid1, blk_ready1, en1, kin1, hdr_err1, busy1;
  logic [65:0] blk_in1;
  logic [7:0]  data_out1;
  logic [15:0] err_cnt1;

  gb66_to_byte #(.BYTE_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_in(blk_in),
    .blk_ready(blk_ready), .en(en), .data_out(data_out), .kin(kin),
    .hdr_err(hdr_err), .err_cnt(err_cnt), .busy(busy)
  );

  gb66_to_byte #(.BYTE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst1), .blk_valid(blk_valid1), .blk_in(blk_in1),
    .blk_ready(blk_ready1), .en(en1), .data_out(data_out1), .kin(kin1),
    .hdr_err(hdr_err1), .err_cnt(err_cnt1), .busy(busy1)
  );

  typedef struct packed {
    logic [7:0]  data;
    logic        kin;
    logic        hdr_err;
    logic        ready;
    logic [15:0] err;
  } exp_t;

  exp_t        exp_q[$];
  int          runs[$];
  int          run_len   = 0;
  bit          mon_on    = 1'b0;
  logic [15:0] model_err = 16'd0;
  logic [15:0] last_err  = 16'd0;
  int          n_checks  = 0;
  int          n_fail    = 0;
  exp_t        mon_e;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected output for every cycle of one accepted block.
  task automatic push_block(input logic [1:0] hdr, input logic [63:0] pl);
    exp_t e;
    logic bad;
    bad = !(hdr == 2'b01 || hdr == 2'b10);
    if (bad && model_err != 16'hFFFF) model_err = model_err + 16'd1;
    for (int k = 0; k < 8; k++) begin
      for (int s = 0; s < BC; s++) begin
        if (bad) begin
          e.data = 8'hFE; e.kin = 1'b1;
        end else if (hdr == 2'b10 && k == 0) begin
          e.data = 8'hBC; e.kin = 1'b1;
        end else begin
          e.data = pl[8*k +: 8]; e.kin = 1'b0;
        end
        e.hdr_err = bad && (k == 0) && (s == 0);
        e.ready   = (k == 7) && (s == BC - 1);
        e.err     = model_err;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a block and wait (bounded) until it is accepted; blk_valid is
  // left high so consecutive calls run back-to-back.
  task automatic send_block(input logic [1:0] hdr, input logic [63:0] pl);
    int waited;
    waited    = 0;
    blk_valid = 1'b1;
    blk_in    = {pl, hdr};
    #1;
    while (!blk_ready && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!blk_ready) begin
      check("accept_timeout", 32'(0), 32'(1));
      blk_valid = 1'b0;
    end else begin
      push_block(hdr, pl);
      tick();
    end
  endtask

  task automatic go_idle();
    blk_valid = 1'b0;
    blk_in    = '0;
  endtask

  task automatic check_run(input string name, input int req);
    if (runs.size() == 0) check(name, 32'(0), 32'(req));
    else check(name, 32'(runs.pop_front()), 32'(req));
  endtask

  // Monitor: compares the DUT against the scoreboard on falling edges.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        check("busy_eq_en", 32'(busy), 32'(en));
        if (en) begin
          run_len++;
          if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(1), 32'(0));
          end else begin
            mon_e = exp_q.pop_front();
            check("data_out", 32'(data_out), 32'(mon_e.data));
            check("kin", 32'(kin), 32'(mon_e.kin));
            check("hdr_err", 32'(hdr_err), 32'(mon_e.hdr_err));
            check("blk_ready_send", 32'(blk_ready), 32'(mon_e.ready));
            check("err_cnt", 32'(err_cnt), 32'(mon_e.err));
            last_err = mon_e.err;
          end
        end else begin
          if (run_len != 0) begin
            runs.push_back(run_len);
            run_len = 0;
          end
          check("idle_data_out", 32'(data_out), 32'(0));
          check("idle_kin", 32'(kin), 32'(0));
          check("idle_hdr_err", 32'(hdr_err), 32'(0));
          check("idle_blk_ready", 32'(blk_ready), 32'(!rst));
          check("idle_err_cnt", 32'(err_cnt), 32'(last_err));
        end
      end
    end
  end

  initial begin
    logic [63:0] pl1;
    rst = 1'b1; blk_valid = 1'b0; blk_in = '0;
    rst1 = 1'b1; blk_valid1 = 1'b0; blk_in1 = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_ready_low", 32'(blk_ready), 32'(0));
    rst = 1'b0; rst1 = 1'b0;
    #1;
    check("reset_en", 32'(en), 32'(0));
    check("reset_data_out", 32'(data_out), 32'(0));
    check("reset_kin", 32'(kin), 32'(0));
    check("reset_hdr_err", 32'(hdr_err), 32'(0));
    check("reset_err_cnt", 32'(err_cnt), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_ready", 32'(blk_ready), 32'(1));
    mon_on = 1'b1;
    tick();

    // Data block: bytes 00..07 as D-symbols.
    send_block(2'b01, 64'h0706050403020100);
    go_idle();
    repeat (28) tick();
    check_run("run_data", 24);

    // Control block: K28.5 then payload bytes 1..7.
    send_block(2'b10, 64'hF7E6D5C4B3A2911E);
    go_idle();
    repeat (28) tick();
    check_run("run_ctrl", 24);

    // Bad header 11 then bad header 00 back-to-back.
    send_block(2'b11, 64'h0123456789ABCDEF);
    send_block(2'b00, 64'hFEDCBA9876543210);
    go_idle();
    repeat (52) tick();
    check_run("run_bad_pair", 48);
    check("err_cnt_two", 32'(err_cnt), 32'(2));

    // Three back-to-back data blocks.
    send_block(2'b01, 64'h1122334455667788);
    send_block(2'b01, 64'h99AABBCCDDEEFF00);
    send_block(2'b01, 64'h0F1E2D3C4B5A6978);
    go_idle();
    repeat (76) tick();
    check_run("run_b2b", 72);

    // Reset wins over a simultaneous handshake.
    rst = 1'b1; blk_valid = 1'b1; blk_in = {64'h5555AAAA5555AAAA, 2'b01};
    tick();
    rst = 1'b0; go_idle();
    model_err = 16'd0; last_err = 16'd0;
    #1;
    check("rst_priority_en", 32'(en), 32'(0));
    check("rst_priority_err", 32'(err_cnt), 32'(0));
    tick();

    // Bad block first so the counter is nonzero, then reset mid-block.
    send_block(2'b11, 64'h0);
    go_idle();
    repeat (28) tick();
    check_run("run_bad_single", 24);
    send_block(2'b01, 64'hCAFEBABEDEADBEEF);
    go_idle();
    repeat (13) tick();
    rst = 1'b1;
    #1;
    check("rst_mid_ready_low", 32'(blk_ready), 32'(0));
    tick();
    rst = 1'b0;
    exp_q.delete();
    model_err = 16'd0; last_err = 16'd0;
    #1;
    check("abort_en", 32'(en), 32'(0));
    check("abort_err_cnt", 32'(err_cnt), 32'(0));
    check("abort_ready", 32'(blk_ready), 32'(1));
    tick();
    check_run("run_aborted", 14);

    // Block after the abort starts again at byte 0.
    send_block(2'b01, 64'h8877665544332211);
    go_idle();
    repeat (28) tick();
    check_run("run_after_abort", 24);
    check("sb_drained", 32'(exp_q.size()), 32'(0));

    // BYTE_CYCLES=1 instance: eight consecutive bytes, ready only on byte 7.
    pl1 = 64'hA7A6A5A4A3A2A1A0;
    blk_valid1 = 1'b1; blk_in1 = {pl1, 2'b01};
    #1;
    check("bc1_idle_ready", 32'(blk_ready1), 32'(1));
    tick();
    blk_valid1 = 1'b0; blk_in1 = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("bc1_en", 32'(en1), 32'(1));
      check("bc1_data", 32'(data_out1), 32'(pl1[8*k +: 8]));
      check("bc1_kin", 32'(kin1), 32'(0));
      check("bc1_ready", 32'(blk_ready1), 32'(k == 7));
      tick();
    end
    #1;
    check("bc1_done_en", 32'(en1), 32'(0));
    check("bc1_done_data", 32'(data_out1), 32'(0));
    check("bc1_done_ready", 32'(blk_ready1), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
